// File: rtl/wave_display_mc.sv
// wave_display_mc: multi-channel waveform renderer with per-frame bank latch, line/dot traces and grid
module wave_display_mc #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int IDX_W    = 8,
  parameter int X_START  = 258,
  parameter int Y_START  = 0,
  parameter int Y_SPAN   = 512,
  parameter int X_SHIFT  = 1,
  parameter int V_SHIFT  = 1,
  parameter int Y_OFFSET = 32,
  parameter int GRID_X   = 64,
  parameter int GRID_Y   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [1:0]                   mode,
  input  logic [24*NUM_CH-1:0]         ch_color,
  input  logic [SAMPLE_W*NUM_CH-1:0]   read_value,
  output logic [IDX_W:0]               read_address,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);
  localparam int Y_W   = 16;
  localparam int X_END = X_START + ((1 << IDX_W) << X_SHIFT);
  localparam int Y_END = Y_START + Y_SPAN;
  localparam int Y_MAX = Y_END - 1;
  logic              bank, in_win, in_win1, first, upd, grid;
  logic [IDX_W-1:0]  idx, idx1, last_idx;
  logic [10:0]       x1;
  logic [9:0]        y1;
  logic [Y_W-1:0]    adj [NUM_CH];
  logic [Y_W-1:0]    cur [NUM_CH];
  logic [Y_W-1:0]    prev [NUM_CH];
  logic [Y_W-1:0]    cur_n [NUM_CH];
  logic [Y_W-1:0]    prev_n [NUM_CH];
  logic [Y_W-1:0]    lo, hi, yw;
  logic [NUM_CH-1:0] hit;
  logic [23:0]       color;
  // Window test and RAM address, then saturated sample rows, next trace endpoints, hit test and color priority
  always_comb begin
    in_win = reset && valid && int'(x) >= X_START && int'(x) < X_END && int'(y) >= Y_START && int'(y) < Y_END;
    idx = IDX_W'((int'(x) - X_START) >> X_SHIFT);
    read_address = {bank, in_win ? idx : '0};
    upd = in_win1 && (first || idx1 != last_idx);
    yw = Y_W'(y1);
    grid = mode[1] && ((((int'(x1) - X_START) & (GRID_X - 1)) == 0) || (((int'(y1) - Y_START) & (GRID_Y - 1)) == 0));
    color = grid ? 24'h404040 : 24'h000000;
    hit = '0;
    lo = '0;
    hi = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      adj[c] = Y_W'(read_value[SAMPLE_W*c +: SAMPLE_W] >> V_SHIFT) + Y_W'(Y_OFFSET);
      adj[c] = int'(adj[c]) > Y_MAX ? Y_W'(Y_MAX) : adj[c];
      cur_n[c] = upd ? adj[c] : cur[c];
      prev_n[c] = upd ? (first ? adj[c] : cur[c]) : prev[c];
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      lo = prev_n[c] < cur_n[c] ? prev_n[c] : cur_n[c];
      hi = prev_n[c] < cur_n[c] ? cur_n[c] : prev_n[c];
      hit[c] = ch_enable[c] && (mode[0] ? yw == cur_n[c] : (yw >= lo && yw <= hi));
      color = hit[c] ? ch_color[24*c +: 24] : color;
    end
  end
  // Bank latch at frame start, pixel pipeline, per-line sample tracking and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      bank <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      in_win1 <= 1'b0;
      idx1 <= '0;
      last_idx <= '0;
      first <= 1'b1;
      cur <= '{default: '0};
      prev <= '{default: '0};
      valid_pixel <= 1'b0;
      {r, g, b} <= 24'h000000;
    end else begin
      if (valid && x == 11'd0 && y == 10'd0) bank <= read_index;
      x1 <= x;
      y1 <= y;
      in_win1 <= in_win;
      idx1 <= idx;
      if (upd) begin
        last_idx <= idx1;
        first <= 1'b0;
      end else if (!in_win1) first <= 1'b1;
      cur <= cur_n;
      prev <= prev_n;
      valid_pixel <= in_win1;
      {r, g, b} <= in_win1 ? color : 24'h000000;
    end
  end
endmodule

// File: tb/tb_wave_display_mc.sv
// tb_wave_display_mc: scoreboard bench driving two renderers (full and 100-row window) from shared sample RAMs
module tb_wave_display_mc;
  typedef struct packed { logic [24:0] e0; logic [24:0] e1; } exp_t;
  logic        clk = 1'b0, reset = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        valid = 1'b0, read_index = 1'b0;
  logic [1:0]  ch_enable = 2'b11, mode = 2'b00;
  logic [47:0] ch_color = {24'h00FF00, 24'hFF0000};
  logic [15:0] rv0, rv1;
  logic [8:0]  ra0, ra1;
  logic        vp0, vp1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic [7:0]  mem [2][512];
  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  int          m_first[2], m_last[2], m_cur[2][2], m_prev[2][2];
  logic        m_bank = 1'b0;
  bit          started = 0;
  always #5 clk = ~clk;
  wave_display_mc dut0 (.clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
    .ch_enable(ch_enable), .mode(mode), .ch_color(ch_color), .read_value(rv0), .read_address(ra0),
    .valid_pixel(vp0), .r(r0), .g(g0), .b(b0));
  wave_display_mc #(.Y_SPAN(100)) dut1 (.clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
    .ch_enable(ch_enable), .mode(mode), .ch_color(ch_color), .read_value(rv1), .read_address(ra1),
    .valid_pixel(vp1), .r(r1), .g(g1), .b(b1));
  // Sample RAMs with one-cycle read latency
  always_ff @(posedge clk) begin
    rv0 <= {mem[1][ra0], mem[0][ra0]};
    rv1 <= {mem[1][ra1], mem[0][ra1]};
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic cyc(input int xx, input int yy, input logic vv);
    exp_t e = '0;
    int span[2] = '{512, 100};
    bit inw, h;
    int idx, a, lo, hi;
    logic [8:0] ea;
    logic [23:0] col;
    x = 11'(xx);
    y = 10'(yy);
    valid = vv;
    #1;
    for (int i = 0; i < 2; i++) begin
      inw = reset && vv && xx >= 258 && xx < 770 && yy < span[i];
      idx = inw ? (xx - 258) >> 1 : 0;
      ea = {m_bank, 8'(idx)};
      if (started) check($sformatf("addr%0d x=%0d y=%0d", i, xx, yy), 32'(i == 0 ? ra0 : ra1), 32'(ea));
      col = 24'h000000;
      if (!reset) begin
        m_first[i] = 1;
        m_last[i] = 0;
        for (int c = 0; c < 2; c++) begin
          m_cur[i][c] = 0;
          m_prev[i][c] = 0;
        end
      end else if (!inw) m_first[i] = 1;
      else begin
        if (m_first[i] != 0 || idx != m_last[i]) begin
          for (int c = 0; c < 2; c++) begin
            a = (int'(mem[c][ea]) >> 1) + 32;
            if (a > span[i] - 1) a = span[i] - 1;
            m_prev[i][c] = m_first[i] != 0 ? a : m_cur[i][c];
            m_cur[i][c] = a;
          end
          m_last[i] = idx;
          m_first[i] = 0;
        end
        if (mode[1] && (((xx - 258) % 64) == 0 || (yy % 64) == 0)) col = 24'h404040;
        for (int c = 1; c >= 0; c--) begin
          lo = m_prev[i][c] < m_cur[i][c] ? m_prev[i][c] : m_cur[i][c];
          hi = m_prev[i][c] < m_cur[i][c] ? m_cur[i][c] : m_prev[i][c];
          h = ch_enable[c] && (mode[0] ? yy == m_cur[i][c] : (yy >= lo && yy <= hi));
          if (h) col = ch_color[24*c +: 24];
        end
      end
      if (i == 0) e.e0 = {inw, col};
      else e.e1 = {inw, col};
    end
    if (!reset) m_bank = 1'b0;
    else if (vv && xx == 0 && yy == 0) m_bank = read_index;
    if (!reset && q.size() > 0) q[$] = '0;
    q.push_back(e);
    @(negedge clk);
    started = 1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      check("pix0", 32'({vp0, r0, g0, b0}), 32'(e.e0));
      check("pix1", 32'({vp1, r1, g1, b1}), 32'(e.e1));
    end
  endtask
  task automatic scan(input int yy, input int xa, input int xb);
    for (int xx = xa; xx <= xb; xx++) cyc(xx, yy, 1'b1);
    cyc(0, 1, 1'b0);
    cyc(0, 1, 1'b0);
  endtask
  initial begin
    for (int c = 0; c < 2; c++) for (int a = 0; a < 512; a++) mem[c][a] = 8'd0;
    mem[0][0] = 8'd100; mem[0][1] = 8'd140; mem[0][2] = 8'd60; mem[0][3] = 8'd255;
    mem[1][0] = 8'd110; mem[1][1] = 8'd120;
    for (int k = 0; k < 8; k++) begin
      mem[0][256+k] = 8'd50;
      mem[1][256+k] = 8'd20;
    end
    reset = 1'b0;
    repeat (3) cyc(300, 50, 1'b1);
    check("reset_addr", 32'(ra0), 32'h000);
    check("reset_vp", 32'({vp0, r0, g0, b0}), 32'h0);
    reset = 1'b1;
    cyc(0, 1, 1'b0);
    read_index = 1'b0;
    cyc(0, 0, 1'b1);
    for (int yy = 80; yy <= 104; yy++) scan(yy, 256, 266);
    ch_enable = 2'b10;
    scan(90, 256, 262);
    ch_enable = 2'b11;
    mode = 2'b11;
    scan(10, 256, 330);
    scan(64, 256, 266);
    scan(82, 256, 266);
    for (int yy = 97; yy <= 100; yy++) scan(yy, 256, 266);
    scan(159, 256, 266);
    mode = 2'b10;
    scan(64, 256, 330);
    mode = 2'b00;
    for (int xx = 258; xx <= 263; xx++) begin
      reset = (xx != 261);
      cyc(xx, 90, 1'b1);
    end
    reset = 1'b1;
    scan(90, 264, 268);
    read_index = 1'b1;
    cyc(0, 0, 1'b1);
    read_index = 1'b0;
    scan(57, 256, 266);
    scan(42, 256, 266);
    cyc(0, 0, 1'b0);
    scan(57, 256, 262);
    cyc(0, 0, 1'b1);
    scan(82, 256, 262);
    repeat (2) cyc(0, 1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
